// File: rtl/uart_rx_if.sv
// Bus window for the UART receiver: select, read strobe, byte-lane writes and combinational read data.
interface uart_rx_if;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] address_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;

  modport master (
    output sel_in, read_in, write_mask_in, address_in, write_value_in,
    input  read_value_out
  );

  modport slave (
    input  sel_in, read_in, write_mask_in, address_in, write_value_in,
    output read_value_out
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, receive buffer and W1C error flags.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_in,
  output logic      rx_irq_out,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic [15:0] clk_div_q;
  logic        sync1_q, rx_sync;
  logic        overrun_q, frame_err_q;
  logic        push, frame_set, pop, do_push, valid, full;
  logic [7:0]  head;
  logic [1:0]  reg_sel;

  logic unused_bus;
  assign unused_bus = ^{bus.address_in[31:4], bus.address_in[1:0],
                        bus.write_value_in[31:16], bus.write_mask_in[3:2]};

  assign reg_sel = bus.address_in[3:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_sync <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_sync) begin
            cnt_q   <= clk_div_q >> 1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (!rx_sync) begin
            cnt_q   <= clk_div_q;
            idx_q   <= '0;
            state_q <= StData;
          end else begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shreg_q <= {rx_sync, shreg_q[7:1]};
            cnt_q   <= clk_div_q;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rx_sync) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWaitHigh;
          end
        end
        StWaitHigh: begin
          if (rx_sync) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push      = (state_q == StStop) && (cnt_q == 16'd0) && rx_sync;
  assign frame_set = (state_q == StStop) && (cnt_q == 16'd0) && !rx_sync;
  assign pop       = bus.sel_in && bus.read_in && (reg_sel == 2'b10) && valid;
  // A pop on the same edge frees the slot, so a push while full still lands.
  assign do_push   = push && (!full || pop);

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 2'd1;
      if (pop)     rp_q <= rp_q + 2'd1;
      if (do_push && !pop)      count_q <= count_q + 3'd1;
      else if (!do_push && pop) count_q <= count_q - 3'd1;
    end
  end

  assign valid = (count_q != 3'd0);
  assign full  = (count_q == 3'd4);
  assign head  = mem_q[rp_q];
`else
  logic [7:0] hold_q;
  logic       count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      count_q <= 1'b0;
    end else if (do_push) begin
      hold_q  <= shreg_q;
      count_q <= 1'b1;
    end else if (pop) begin
      count_q <= 1'b0;
    end
  end

  assign valid = count_q;
  assign full  = count_q;
  assign head  = hold_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_div_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (bus.sel_in && (reg_sel == 2'b00)) begin
        if (bus.write_mask_in[0]) clk_div_q[7:0]  <= bus.write_value_in[7:0];
        if (bus.write_mask_in[1]) clk_div_q[15:8] <= bus.write_value_in[15:8];
      end
      // Setting has priority over a simultaneous W1C.
      if (push && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (bus.sel_in && (reg_sel == 2'b01) && bus.write_mask_in[0] &&
                   bus.write_value_in[1]) begin
        overrun_q <= 1'b0;
      end
      if (frame_set) begin
        frame_err_q <= 1'b1;
      end else if (bus.sel_in && (reg_sel == 2'b01) && bus.write_mask_in[0] &&
                   bus.write_value_in[2]) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.read_value_out = '0;
    if (bus.sel_in) begin
      unique case (reg_sel)
        2'b00:   bus.read_value_out = {16'b0, clk_div_q};
        2'b01:   bus.read_value_out = {28'b0, full, frame_err_q, overrun_q, valid};
        2'b10:   bus.read_value_out = valid ? {24'b0, head} : 32'b0;
        default: bus.read_value_out = '0;
      endcase
    end
  end

  assign rx_irq_out = valid;

endmodule
